mul_seq_ctrl: RTL and testbench

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

---
 rtl/mul_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_mul_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mul_seq_ctrl -- sequential RV32M multiply controller
//
// Computes MUL / MULH / MULHSU / MULHU by converting both operands to
// magnitudes, then accumulating all sixteen 8x8 byte partial products through
// a single shared Multiplier8x8. A final step re-applies the sign before the
// selected product half is registered onto result.
//
// Ports
//   clk     in   1     rising-edge clock
//   rst_n   in   1     asynchronous active-low reset
//   start   in   1     request a multiply (only honoured in IDLE)
//   op      in   2     00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   rs1     in   XLEN  multiplicand, captured with start
//   rs2     in   XLEN  multiplier, captured with start
//   flush   in   1     synchronous abort of the in-flight operation
//   busy    out  1     operation in progress
//   done    out  1     one-cycle pulse, result valid
//   result  out  XLEN  selected product half, held until the next done
//
// Timing: start accepted at edge E0 -> 16 CALC cycles, SIGN, DONE; done and
// the new result are visible in the cycle beginning at edge E18. The next
// start can be accepted at edge E19.
// ---------------------------------------------------------------------------

// 8x8 unsigned multiplier, the only multiply resource of the controller.
module Multiplier8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  assign p = {8'd0, a} * {8'd0, b};

endmodule

module mul_seq_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int ACCW = 2 * XLEN;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;

  logic [3:0]        k_r;
  logic [ACCW-1:0]   acc_r;
  logic [XLEN-1:0]   mag1_r;
  logic [XLEN-1:0]   mag2_r;
  logic              neg_r;
  logic [1:0]        op_r;
  logic [XLEN-1:0]   result_r;
  logic              done_r;
  logic              busy_r;

  logic              rs1_signed_s;
  logic              rs2_signed_s;
  logic              rs1_neg_s;
  logic              rs2_neg_s;
  logic [7:0]        byte1_s;
  logic [7:0]        byte2_s;
  logic [15:0]       prod_s;
  logic [2:0]        shift_s;
  logic [ACCW-1:0]   pp_s;

  // Two's-complement negation of an operand. 0x80000000 maps to itself,
  // which is exactly its unsigned magnitude, so no special case is needed.
  function automatic logic [XLEN-1:0] negate_op(input logic [XLEN-1:0] v);
    return ~v + 32'd1;
  endfunction

  // Magnitude of an operand, negated only when it is read as signed.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic            is_signed);
    logic [XLEN-1:0] m;
    if (is_signed && v[XLEN-1]) begin
      m = negate_op(v);
    end else begin
      m = v;
    end
    return m;
  endfunction

  // Signedness of the incoming operands, decoded from the requested op.
  always_comb begin
    rs1_signed_s = 1'b0;
    rs2_signed_s = 1'b0;
    case (op)
      OP_MUL:    begin rs1_signed_s = 1'b1; rs2_signed_s = 1'b1; end
      OP_MULH:   begin rs1_signed_s = 1'b1; rs2_signed_s = 1'b1; end
      OP_MULHSU: begin rs1_signed_s = 1'b1; rs2_signed_s = 1'b0; end
      default:   begin rs1_signed_s = 1'b0; rs2_signed_s = 1'b0; end
    endcase
    rs1_neg_s = rs1_signed_s & rs1[XLEN-1];
    rs2_neg_s = rs2_signed_s & rs2[XLEN-1];
  end

  // Byte operand selection: k[1:0] walks rs1 bytes, k[3:2] walks rs2 bytes.
  always_comb begin
    byte1_s = 8'd0;
    byte2_s = 8'd0;
    case (k_r[1:0])
      2'd0:    byte1_s = mag1_r[7:0];
      2'd1:    byte1_s = mag1_r[15:8];
      2'd2:    byte1_s = mag1_r[23:16];
      2'd3:    byte1_s = mag1_r[31:24];
      default: byte1_s = 8'd0;
    endcase
    case (k_r[3:2])
      2'd0:    byte2_s = mag2_r[7:0];
      2'd1:    byte2_s = mag2_r[15:8];
      2'd2:    byte2_s = mag2_r[23:16];
      2'd3:    byte2_s = mag2_r[31:24];
      default: byte2_s = 8'd0;
    endcase
  end

  Multiplier8x8 u_mul8 (
    .a (byte1_s),
    .b (byte2_s),
    .p (prod_s)
  );

  // Partial product aligned to byte position i+j of the 64-bit product.
  always_comb begin
    shift_s = {1'b0, k_r[1:0]} + {1'b0, k_r[3:2]};
    pp_s    = {{(ACCW-16){1'b0}}, prod_s} << {shift_s, 3'b000};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_s = state_r;
    if (flush) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_s = CALC;
          end else begin
            state_s = IDLE;
          end
        end
        CALC: begin
          if (k_r == 4'd15) begin
            state_s = SIGN;
          end else begin
            state_s = CALC;
          end
        end
        SIGN:    state_s = DONE;
        DONE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // Datapath: operand capture, accumulation, sign fix-up and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_r      <= 4'd0;
      acc_r    <= 64'd0;
      mag1_r   <= 32'd0;
      mag2_r   <= 32'd0;
      neg_r    <= 1'b0;
      op_r     <= 2'b00;
      result_r <= 32'd0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      // busy covers the cycles from the one after acceptance up to the
      // return to IDLE, and drops together with any flush.
      busy_r <= (state_r != IDLE) && (state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (start && !flush) begin
            op_r   <= op;
            mag1_r <= magnitude(rs1, rs1_signed_s);
            mag2_r <= magnitude(rs2, rs2_signed_s);
            neg_r  <= rs1_neg_s ^ rs2_neg_s;
            acc_r  <= 64'd0;
            k_r    <= 4'd0;
          end
        end
        CALC: begin
          if (flush) begin
            k_r <= 4'd0;
          end else begin
            acc_r <= acc_r + pp_s;
            k_r   <= k_r + 4'd1;
          end
        end
        SIGN: begin
          if (!flush && neg_r) begin
            acc_r <= ~acc_r + 64'd1;
          end
        end
        DONE: begin
          // The result is already final here, so a flush no longer cancels it.
          done_r <= 1'b1;
          if (op_r == OP_MUL) begin
            result_r <= acc_r[XLEN-1:0];
          end else begin
            result_r <= acc_r[ACCW-1:XLEN];
          end
        end
        default: begin
          k_r <= 4'd0;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: expected results are computed with plain
// 64-bit arithmetic when an op is issued and checked when done pulses.
module tb_mul_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int tests;
  int fails;
  int cyc;

  logic [31:0] exp_res[$];
  int          exp_cyc[$];
  logic [31:0] mon_res;
  int          mon_cyc;
  logic [31:0] last_exp;

  mul_seq_ctrl #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: sign- or zero-extend to 64 bits, multiply, pick the half.
  function automatic logic [31:0] ref_mul(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = (o != 2'b11) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (o == 2'b00 || o == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h0000_0000;
      1:       v = 32'h0000_0001;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h7FFF_FFFF;
      4:       v = 32'h8000_0000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_res.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done with result %h, expected no done", result);
      end else begin
        mon_res = exp_res.pop_front();
        mon_cyc = exp_cyc.pop_front();
        check("result", result, mon_res);
        check("latency", 32'(cyc - mon_cyc), 32'd18);
      end
    end
  end

  // Drive a request in the current cycle; it is sampled at the next edge.
  task automatic issue_now(input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input bit push);
    start = 1'b1;
    op    = o;
    rs1   = a;
    rs2   = b;
    @(posedge clk);
    #1;
    if (push) begin
      exp_res.push_back(ref_mul(o, a, b));
      exp_cyc.push_back(cyc);
      last_exp = ref_mul(o, a, b);
    end
    // Scramble inputs after acceptance: they must not affect the op.
    start = 1'b0;
    op    = 2'($urandom);
    rs1   = $urandom;
    rs2   = $urandom;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit push);
    @(negedge clk);
    issue_now(o, a, b, push);
  endtask

  // Wait until the scoreboard drains, counting cycles with busy high.
  task automatic wait_done(output int busy_cnt);
    int n;
    n = 0;
    busy_cnt = 0;
    while (exp_res.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      if (busy) busy_cnt++;
      n++;
    end
    if (exp_res.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: got %0d pending results after %0d cycles, expected 0", exp_res.size(), n);
      exp_res.delete();
      exp_cyc.delete();
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int bc;
    tests    = 0;
    fails    = 0;
    cyc      = 0;
    last_exp = 32'd0;
    rst_n    = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    op       = 2'b00;
    rs1      = 32'd0;
    rs2      = 32'd0;
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic MUL with latency and busy-length checks.
    issue(2'b00, 32'd7, 32'd6, 1'b1);
    wait_done(bc);
    check("busy_cycles", 32'(bc), 32'd17);
    check("busy_after_done", {31'd0, busy}, 32'd0);

    // Directed corner products.
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b1); wait_done(bc);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1); wait_done(bc);
    issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_done(bc);
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_done(bc);
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_done(bc);
    check("mulh_min", ref_mul(2'b01, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    check("mulhsu_m1", ref_mul(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);

    // start during CALC must be ignored.
    issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 2'b11; rs1 = 32'hDEAD_BEEF; rs2 = 32'hCAFE_F00D;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(bc);
    idle_cycles(25);

    // Flush at k=5: no done, busy drops, result holds.
    issue(2'b00, 32'd100, 32'd200, 1'b0);
    repeat (6) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_result_hold", result, last_exp);
    idle_cycles(25);
    check("flush_result_later", result, last_exp);

    // Flush together with start in IDLE drops the request.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b00; rs1 = 32'd9; rs2 = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_start_busy", {31'd0, busy}, 32'd0);
    idle_cycles(25);

    // Flush in DONE: the pulse still happens with the new result.
    issue(2'b11, 32'hFFFF_0000, 32'h0001_FFFF, 1'b1);
    repeat (18) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_done(bc);
    idle_cycles(3);
    check("flush_done_busy", {31'd0, busy}, 32'd0);

    // Reset mid-CALC clears outputs immediately; first edge after release accepts.
    issue(2'b00, 32'd11, 32'd13, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue_now(2'b00, 32'd3, 32'd5, 1'b1);
    wait_done(bc);
    check("post_reset_mul", result, 32'h0000_000F);

    // Random sweep across all op codes with corner operands mixed in.
    for (int n = 0; n < 2000; n++) begin
      issue(2'($urandom), pick(), pick(), 1'b1);
      wait_done(bc);
    end

    idle_cycles(25);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
